// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//
// Holds the FSM state encoding (IDLE=0, RUN=1, PAUSE=2) and the default parameter values
// used by stopwatch_ctrl and key_debounce.
//
// Ports: none (package).

package stopwatch_pkg;

  // Default parameter values.
  localparam int unsigned DefClkHz     = 50_000_000;
  localparam int unsigned DefTickHz    = 1;
  localparam int unsigned DefDebCycles = 1_000_000;

  // Externally visible state codes.
  localparam logic [1:0] StateIdle  = 2'd0;
  localparam logic [1:0] StateRun   = 2'd1;
  localparam logic [1:0] StatePause = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = StateIdle,
    StRun   = StateRun,
    StPause = StatePause
  } sw_state_e;

endpackage : stopwatch_pkg

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter and press-edge pulse.
//
// The debounced level only follows the synchronized key after the two have differed for
// DebCycles consecutive clocks; any return to equality restarts the count. press_o pulses for
// one clock on each debounced 1->0 transition (releases produce nothing).
//
// Ports:
//   clk_i    system clock (rising edge)
//   rst_ni   asynchronous active-low reset
//   key_ni   raw asynchronous key, low = pressed
//   press_o  one-cycle press event

module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DebCycles = DefDebCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  // Synchronizer flops reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_ni;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      // cnt_q counts the differing cycles already seen; this one is the DebCycles-th.
      if (cnt_q == CntW'(DebCycles - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule : key_debounce

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/pause/clear FSM plus tick prescaler for a BCD seconds chain.
//
// Start toggles IDLE->RUN, RUN->PAUSE, PAUSE->RUN; clear returns to IDLE from any state and
// wins over a simultaneous start. The prescaler counts only cycles spent in RUN, holds through
// PAUSE (so resuming keeps the fractional period) and is zeroed on entry to IDLE.
//
// Optional feature macro: STOPWATCH_LAP_EN adds key_lap_n and hold (lap display freeze).
//
// Ports:
//   clk          system clock (rising edge)
//   aclr         asynchronous active-low reset
//   key_start_n  raw start/pause key, low = pressed
//   key_clear_n  raw clear key, low = pressed
//   key_lap_n    raw lap key, low = pressed (STOPWATCH_LAP_EN only)
//   hold         lap hold flag (STOPWATCH_LAP_EN only)
//   tick         one-cycle count enable, CLK_HZ/TICK_HZ cycles of RUN apart
//   clr_n        one-cycle active-low clear for the counter chain
//   run          high while in RUN
//   state        current state code

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DefClkHz,
  parameter int unsigned TICK_HZ    = DefTickHz,
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       key_start_n,
  input  logic       key_clear_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       key_lap_n,
  output logic       hold,
`endif
  output logic       tick,
  output logic       clr_n,
  output logic       run,
  output logic [1:0] state
);

  localparam int unsigned Div  = CLK_HZ / TICK_HZ;
  localparam int unsigned PreW = $clog2(Div);

  logic start_ev, clear_ev;

  key_debounce #(
    .DebCycles(DEB_CYCLES)
  ) u_deb_start (
    .clk_i  (clk),
    .rst_ni (aclr),
    .key_ni (key_start_n),
    .press_o(start_ev)
  );

  key_debounce #(
    .DebCycles(DEB_CYCLES)
  ) u_deb_clear (
    .clk_i  (clk),
    .rst_ni (aclr),
    .key_ni (key_clear_n),
    .press_o(clear_ev)
  );

  sw_state_e       state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            advance;
  logic            tick_q, tick_d;
  logic            clr_n_q, clr_n_d;

  // Next state: clear has priority and swallows a coincident start.
  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = StIdle;
    end else if (start_ev) begin
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler only advances on cycles that stay in RUN, so a tick is never issued on the edge
  // that leaves RUN and the partial period survives a pause intact.
  always_comb begin
    advance = (state_q == StRun) && (state_d == StRun);
    pre_d   = pre_q;
    tick_d  = 1'b0;
    if (state_d == StIdle) begin
      pre_d = '0;
    end else if (advance) begin
      if (pre_q == PreW'(Div - 1)) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    clr_n_d = ~clear_ev;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= StIdle;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_n_q <= clr_n_d;
    end
  end

  assign tick  = tick_q;
  assign clr_n = clr_n_q;
  assign run   = (state_q == StRun);
  assign state = state_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_ev;
  logic hold_q, hold_d;

  key_debounce #(
    .DebCycles(DEB_CYCLES)
  ) u_deb_lap (
    .clk_i  (clk),
    .rst_ni (aclr),
    .key_ni (key_lap_n),
    .press_o(lap_ev)
  );

  always_comb begin
    hold_d = hold_q;
    if (clear_ev) begin
      hold_d = 1'b0;
    end else if (lap_ev && (state_q == StRun)) begin
      hold_d = ~hold_q;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;
`endif

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with CLK_HZ=10, TICK_HZ=1, DEB_CYCLES=4.
// A cycle-level behavioural model predicts tick/clr_n/run/state every cycle; directed
// sequences add hand-computed timing expectations.

module tb_stopwatch_ctrl;

  localparam int unsigned ClkHz = 10;
  localparam int unsigned TickHz = 1;
  localparam int unsigned Deb = 4;
  localparam int Div = 10;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic       ks_n = 1'b1;
  logic       kc_n = 1'b1;
  logic       tick, clr_n, run;
  logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
  logic       kl_n = 1'b1;
  logic       hold;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  stopwatch_ctrl #(
    .CLK_HZ    (ClkHz),
    .TICK_HZ   (TickHz),
    .DEB_CYCLES(Deb)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .key_start_n(ks_n),
    .key_clear_n(kc_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n  (kl_n),
    .hold       (hold),
`endif
    .tick       (tick),
    .clr_n      (clr_n),
    .run        (run),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per key: last two raw samples, debounced level, length of current disagreement run,
  // and whether a press event is visible this cycle. Index 0 = start, 1 = clear.
  int ms1[2], ms2[2], mlvl[2], mrun[2];
  bit mev[2];
  int mst;      // 0 idle, 1 run, 2 pause
  int elapsed;  // RUN->RUN cycles since last entry to idle
  bit etick, eclrn;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      ms1[k] = 1; ms2[k] = 1; mlvl[k] = 1; mrun[k] = 0; mev[k] = 1'b0;
    end
    mst = 0; elapsed = 0; etick = 1'b0; eclrn = 1'b1;
  endfunction

  function automatic void model_step(input int raw0, input int raw1);
    int nst;
    int raw[2];
    bit sev, cev;
    raw[0] = raw0; raw[1] = raw1;
    sev = mev[0]; cev = mev[1];
    nst = mst;
    if (cev) nst = 0;
    else if (sev) nst = (mst == 1) ? 2 : 1;
    if (nst == 0) begin
      elapsed = 0; etick = 1'b0;
    end else if (mst == 1 && nst == 1) begin
      elapsed++;
      etick = (elapsed % Div == 0);
    end else begin
      etick = 1'b0;
    end
    eclrn = !cev;
    mst = nst;
    for (int k = 0; k < 2; k++) begin
      mev[k] = 1'b0;
      if (ms2[k] != mlvl[k]) begin
        mrun[k]++;
        if (mrun[k] == Deb) begin
          mlvl[k] = ms2[k];
          mrun[k] = 0;
          mev[k] = (mlvl[k] == 0);
        end
      end else begin
        mrun[k] = 0;
      end
      ms2[k] = ms1[k];
      ms1[k] = raw[k];
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge aclr);
      if (!aclr) model_reset();
      else model_step(int'(ks_n), int'(kc_n));
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("tick", int'(tick), int'(etick));
        check("clr_n", int'(clr_n), int'(eclrn));
        check("run", int'(run), (mst == 1) ? 1 : 0);
        check("state", int'(state), mst);
      end
    end
  end

  // Event monitor for the hand-computed timing checks.
  int ncyc = 0, tick_cnt = 0, clr_low_cnt = 0, run_entries = 0, pause_entries = 0;
  int last_tick = 0, last_run = 0, prev_state = 0;
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (tick === 1'b1) begin tick_cnt++; last_tick = ncyc; end
      if (clr_n === 1'b0) clr_low_cnt++;
      if (state == 2'd1 && prev_state != 1) begin run_entries++; last_run = ncyc; end
      if (state == 2'd2 && prev_state != 2) pause_entries++;
      prev_state = int'(state);
    end
  end

  task automatic nwait(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      nwait(1);
      n++;
    end
    check("wait_state", int'(state), s);
  endtask

  task automatic wait_tick(input int snap, input int budget);
    int n = 0;
    while (tick_cnt == snap && n < budget) begin
      nwait(1);
      n++;
    end
    check("wait_tick", (tick_cnt > snap) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, snap, t1, tp, c0, r0;
    #1 aclr = 1'b0;
    nwait(3);
    chk_en = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_clr_n", int'(clr_n), 1);
    check("rst_run", int'(run), 0);

    // Idle with keys released.
    aclr = 1'b1;
    nwait(50);
    check("idle_ticks", tick_cnt, 0);
    check("idle_clr", clr_low_cnt, 0);
    check("idle_state", int'(state), 0);

    // Long start press: 2 sync + 4 debounce + 1 FSM = 7 cycles to RUN.
    p = ncyc;
    ks_n = 1'b0; nwait(10); ks_n = 1'b1;
    check("run_entries", run_entries, 1);
    check("start_latency", last_run - p, 7);
    snap = tick_cnt; wait_tick(snap, 30);
    check("first_tick", last_tick - last_run, 10);
    t1 = last_tick;
    snap = tick_cnt; wait_tick(snap, 30);
    check("tick_period", last_tick - t1, 10);

    // 3-cycle glitch is filtered.
    nwait(12);
    ks_n = 1'b0; nwait(3); ks_n = 1'b1;
    nwait(15);
    check("short_state", int'(state), 1);
    check("short_pause", pause_entries, 0);

    // Pause after 15 RUN cycles past a tick boundary, resume -> tick 5 cycles later.
    snap = tick_cnt; wait_tick(snap, 30);
    nwait(9);
    ks_n = 1'b0; nwait(6); ks_n = 1'b1;
    wait_state(2, 20);
    tp = tick_cnt;
    nwait(20);
    check("pause_state", int'(state), 2);
    ks_n = 1'b0; nwait(6); ks_n = 1'b1;
    wait_state(1, 20);
    check("pause_no_tick", tick_cnt, tp);
    snap = tick_cnt; wait_tick(snap, 30);
    check("resume_tick", last_tick - last_run, 5);

    // Clear in RUN, then restart from zero.
    nwait(12);
    c0 = clr_low_cnt;
    kc_n = 1'b0; nwait(6); kc_n = 1'b1;
    wait_state(0, 20);
    nwait(12);
    check("clear_pulses", clr_low_cnt - c0, 1);
    check("clear_state", int'(state), 0);
    ks_n = 1'b0; nwait(6); ks_n = 1'b1;
    wait_state(1, 20);
    snap = tick_cnt; wait_tick(snap, 30);
    check("restart_tick", last_tick - last_run, 10);

    // Simultaneous start and clear from PAUSE: clear wins.
    nwait(5);
    ks_n = 1'b0; nwait(6); ks_n = 1'b1;
    wait_state(2, 20);
    nwait(12);
    c0 = clr_low_cnt; r0 = run_entries;
    ks_n = 1'b0; kc_n = 1'b0; nwait(6); ks_n = 1'b1; kc_n = 1'b1;
    nwait(20);
    check("both_state", int'(state), 0);
    check("both_clr", clr_low_cnt - c0, 1);
    check("both_run", run_entries, r0);

    // Reset mid-period in RUN with a start key mid-debounce.
    ks_n = 1'b0; nwait(6); ks_n = 1'b1;
    wait_state(1, 20);
    nwait(15);
    ks_n = 1'b0; nwait(2);
    aclr = 1'b0; ks_n = 1'b1;
    nwait(3);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_clr_n", int'(clr_n), 1);
    check("mid_rst_run", int'(run), 0);
    t1 = tick_cnt; r0 = run_entries; c0 = clr_low_cnt;
    aclr = 1'b1;
    nwait(30);
    check("post_rst_ticks", tick_cnt - t1, 0);
    check("post_rst_runs", run_entries - r0, 0);
    check("post_rst_clr", clr_low_cnt - c0, 0);
    check("post_rst_state", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stopwatch_ctrl
